// File: rtl/crc16_frame_chk_pkg.sv
// crc16_chk_pkg: shared constants and types for the CRC-16/USB frame checker.
//   CRC16_INIT      - CRC register preset at start of frame
//   CRC16_XOROUT    - final XOR applied to the CRC register
//   CRC16_POLY_REFL - x^16+x^15+x^2+1 in bit-reflected form (LSB-first update)
//   state_t         - frame FSM states
package crc16_chk_pkg;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT    = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_frame_chk_if.sv
// crc16_frame_chk_if: byte-stream in, payload stream out, frame status.
//   in_*      : received frame bytes (payload, CRC lo, CRC hi), valid/ready
//   out_*     : payload bytes with CRC stripped, valid/ready
//   frm_*/err_*: one-cycle frame status while frm_done=1
//   slave  modport: the checker; master modport: the source/sink around it.
interface crc16_frame_chk_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_ready;
  logic        frm_done;
  logic        frm_ok;
  logic        err_short;
  logic        err_long;
  logic [15:0] frm_len;

  modport slave (
    input  in_data, in_valid, in_sof, in_eof, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eof,
    output frm_done, frm_ok, err_short, err_long, frm_len
  );

  modport master (
    output in_data, in_valid, in_sof, in_eof, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eof,
    input  frm_done, frm_ok, err_short, err_long, frm_len
  );
endinterface

// File: rtl/crc16_frame_chk_step.sv
// crc16_usb_step: combinational one-byte CRC-16/USB update.
//   crc_in    - current CRC register (reflected form)
//   data_byte - byte to absorb, LSB first
//   crc_out   - updated CRC register
// The register is kept bit-reflected, so the textbook "reverse the result"
// step is implicit; only the XOROUT remains at the end of a frame.
module crc16_usb_step
  import crc16_chk_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {8'h00, data_byte};
    for (int unsigned i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC16_POLY_REFL) : (acc >> 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc16_frame_chk.sv
// crc16_frame_chk: receives frames (payload + CRC-16/USB lo,hi), forwards the
// payload with the CRC bytes stripped and reports CRC match / short / long.
//   clk, rst (async, active-low)
//   bus (crc16_frame_chk_if.slave): in_* stream, out_* stream, frame status
//   MAX_LEN: payload byte count above which err_long is raised
// Optional macro CRC16_CHK_LEN_EN: payload length counter, frm_len, err_long.
// Without it frm_len reads 0 and err_long reads 0.
module crc16_frame_chk
  import crc16_chk_pkg::*;
#(
  parameter logic [15:0] MAX_LEN = 16'd4096
) (
  input  logic               clk,
  input  logic               rst,
  crc16_frame_chk_if.slave   bus
);

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_nxt;
  logic [7:0]  d_old, d_new;     // 2-byte delay line; d_old is the oldest
  logic [1:0]  dl_cnt;
  logic        evicted;          // at least one payload byte left this frame
  logic [7:0]  out_data_q;
  logic        out_valid_q, out_sof_q, out_eof_q;
  logic        in_ready_c, accept, evict, done;

  assign accept = bus.in_valid && in_ready_c;
  assign evict  = (state_q == RX) && accept && (dl_cnt == 2'd2);
  assign done   = (state_q == DONE);

  crc16_usb_step u_step (
    .crc_in    (crc_q),
    .data_byte (d_old),
    .crc_out   (crc_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; a single byte carrying both sof and eof goes straight to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && bus.in_sof) state_d = bus.in_eof ? DONE : RX;
      RX:   if (accept && bus.in_eof) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_c    = (state_q != DONE) && (!out_valid_q || bus.out_ready);
    bus.in_ready  = in_ready_c;
    bus.frm_done  = done;
    bus.err_short = done && !evicted;
    // After eof the delay line holds the received CRC as {hi, lo}
    bus.frm_ok    = done && evicted && ({d_new, d_old} == (crc_q ^ CRC16_XOROUT));
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
    bus.out_sof   = out_sof_q;
    bus.out_eof   = out_eof_q;
  end

  // Delay line, CRC and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q       <= CRC16_INIT;
      d_old       <= '0;
      d_new       <= '0;
      dl_cnt      <= '0;
      evicted     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (state_q == IDLE && accept && bus.in_sof) begin
        crc_q   <= CRC16_INIT;
        d_old   <= '0;
        d_new   <= bus.in_data;
        dl_cnt  <= 2'd1;
        evicted <= 1'b0;
      end else if (state_q == RX && accept) begin
        d_old <= d_new;
        d_new <= bus.in_data;
        if (evict) begin
          out_data_q  <= d_old;
          out_valid_q <= 1'b1;
          out_sof_q   <= !evicted;
          out_eof_q   <= bus.in_eof;
          crc_q       <= crc_nxt;
          evicted     <= 1'b1;
        end else begin
          dl_cnt <= 2'd2;
        end
      end
    end
  end

`ifdef CRC16_CHK_LEN_EN
  logic [15:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
    end else if (state_q == IDLE && accept && bus.in_sof) begin
      len_q <= '0;
    end else if (evict && len_q != 16'hFFFF) begin
      len_q <= len_q + 16'd1;
    end
  end

  always_comb begin
    bus.frm_len  = done ? len_q : '0;
    bus.err_long = done && (len_q > MAX_LEN);
  end
`else
  logic unused_max_len;
  assign unused_max_len = ^MAX_LEN;

  always_comb begin
    bus.frm_len  = '0;
    bus.err_long = 1'b0;
  end
`endif

endmodule

// File: doc/crc16_frame_chk.md
CRC16_FRAME_CHK -- requirements
Module: crc16_frame_chk

Interface
REQ-001 Parameter MAX_LEN, default 16'd4096, payload byte count above which err_long is flagged.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  8  received frame byte; payload first, then CRC low byte, then CRC high byte.
REQ-005 in_valid  input  1  in_data valid; a byte is accepted when in_valid && in_ready.
REQ-006 in_sof / in_eof  input  1 each  first / last byte of frame, qualified by acceptance.
REQ-007 in_ready  output  1  block can accept a byte.
REQ-008 out_data  output  8  payload byte with CRC bytes stripped.
REQ-009 out_valid / out_sof / out_eof  output  1 each  output byte valid / first payload byte / last payload byte.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
REQ-011 frm_done  output  1  one-cycle frame status strobe.
REQ-012 frm_ok / err_short / err_long  output  1 each  CRC match / frame under 3 bytes / payload over MAX_LEN; valid while frm_done=1.
REQ-013 frm_len  output  16  payload byte count, excluding CRC bytes; valid while frm_done=1.

Function
REQ-014 CRC SHALL be CRC-16/USB: poly x^16+x^15+x^2+1, LSB-first per byte, init 16'hFFFF, result bit-reversed and XORed with 16'hFFFF; "123456789" -> 16'hB4C8.
REQ-015 FSM states: IDLE, RX, DONE; IDLE->RX on accepted byte with in_sof=1; RX->DONE on accepted byte with in_eof=1; DONE->IDLE after exactly one cycle.
REQ-016 Accepted sof byte SHALL set the CRC to init, clear the length counter, and load the 2-byte delay line with that byte.
REQ-017 Bytes accepted in IDLE without in_sof SHALL be dropped; in_sof in RX SHALL be ignored.
REQ-018 In RX, when the delay line holds 2 bytes, each accepted byte SHALL evict the oldest byte to the output register and the CRC update in the same cycle; 1-cycle latency from eviction to out_valid.
REQ-019 in_ready = (state != DONE) && (!out_valid || out_ready); out_* held stable while out_valid && !out_ready.
REQ-020 First evicted byte of a frame carries out_sof=1; byte evicted on eof acceptance carries out_eof=1.
REQ-021 On eof the two delay-line bytes after eviction SHALL be the received CRC {hi,lo}; in DONE, frm_ok=1 iff that equals the final CRC and the frame has at least 3 bytes.
REQ-022 Frame of 1 or 2 bytes, including sof and eof on the same byte: nothing emitted, err_short=1, frm_ok=0, frm_len=0.
REQ-023 Length counter SHALL saturate at 16'hFFFF; err_long=1 when frm_len > MAX_LEN; frm_ok is independent of err_long.
REQ-024 frm_done, frm_ok, err_short and err_long SHALL be 0 outside DONE.

Reset
REQ-025 rst low: state=IDLE, CRC=16'hFFFF, delay line and counter cleared, all outputs 0 except in_ready.
REQ-026 in_ready SHALL be 1 one cycle after rst deasserts.
REQ-027 Reset mid-frame SHALL discard the partial frame with no frm_done; a pending out_valid byte is lost.

Configuration
REQ-028 Macro CRC16_CHK_LEN_EN defined: length counter, frm_len and err_long implemented per REQ-023.
REQ-029 Macro absent: no counter; frm_len tied 16'd0 and err_long tied 0; all other behaviour identical.

Structure
REQ-030 Package crc16_chk_pkg SHALL hold CRC16_INIT=16'hFFFF, CRC16_XOROUT=16'hFFFF and the FSM state typedef.
REQ-031 Sub-module crc16_usb_step SHALL be the combinational one-byte CRC update (crc_in, byte -> crc_out), instantiated once.

Verification
REQ-032 Frame 31..39 + C8,B4, out_ready=1 -> 9 out bytes 31..39 with sof on 31 and eof on 39; frm_done with frm_ok=1, frm_len=9.
REQ-033 Same frame with last byte B5 -> same 9 out bytes; frm_ok=0.
REQ-034 Frame 31,C8 (2 bytes), and separately a single byte with sof=eof=1 -> no out_valid; err_short=1.
REQ-035 out_ready held 0 for 5 cycles mid-frame -> in_ready=0 within 1 cycle; no byte lost or duplicated; CRC result still 16'hB4C8.
REQ-036 rst pulsed after 4 payload bytes, then good frame -> no frm_done for the aborted frame; next frame frm_ok=1.
REQ-037 With CRC16_CHK_LEN_EN and MAX_LEN=4: 9-byte payload -> err_long=1, frm_ok=1; without the macro -> frm_len=0, err_long=0.
